// File: rtl/mem_stage_pipe.sv
// MEM stage between EX and WB: MEM/WB pipeline register, jump resolution and
// data-RAM access with WAIT_CYCLES wait states, stalling EX while an access is in flight.
module mem_stage_pipe #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned RD_W        = 2,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              wr,
  input  logic              wm,
  input  logic              rm,
  input  logic              neq,
  input  logic              j,
  input  logic              jc,
  input  logic              zero,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] ac_value,
  input  logic [RD_W-1:0]   rd_ex,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_wr,
  output logic              wb_rm,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_ac,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_target
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              load;
  logic              mem_op;
  logic              taken;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] ram [DEPTH];

  assign mem_op = rm | wm;
  assign addr   = ac_value[ADDR_W-1:0];
  assign taken  = j | (jc & (neq ? ~zero : zero));

  // Next state, wait counter and MEM/WB load strobe
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (mem_op && (WAIT_CYCLES != 0)) begin
            state_nx = BUSY;
            cnt_nx   = CNT_W'(WAIT_CYCLES);
            stall    = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          load     = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      wb_valid      <= 1'b0;
      wb_wr         <= 1'b0;
      wb_rm         <= 1'b0;
      wb_rd         <= '0;
      wb_ac         <= '0;
      wb_data       <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      wb_valid     <= load;
      branch_taken <= load & taken;
      if (load) begin
        wb_wr         <= wr;
        wb_rm         <= rm;
        wb_rd         <= rd_ex;
        wb_ac         <= ac_value;
        branch_target <= pc;
        // Read-before-write: the RAM update below lands after this sample
        if (rm) wb_data <= ram[addr];
      end
    end
  end

  // Data RAM is never cleared; a reset mid-access suppresses the write
  always_ff @(posedge clock) begin
    if (load && wm && !reset) ram[addr] <= reg_val;
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: one instance with one wait state, one with three,
// sharing stimulus; each scenario task checks the instance it targets.
module tb_mem_stage_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_valid, wr, wm, rm, neq, j, jc, zero;
  logic [AW-1:0] pc;
  logic [DW-1:0] reg_val, ac_value;
  logic [RW-1:0] rd_ex;

  logic          stall_1, wb_valid_1, wb_wr_1, wb_rm_1, branch_taken_1;
  logic [RW-1:0] wb_rd_1;
  logic [DW-1:0] wb_ac_1, wb_data_1;
  logic [AW-1:0] branch_target_1;

  logic          stall_3, wb_valid_3, wb_wr_3, wb_rm_3, branch_taken_3;
  logic [RW-1:0] wb_rd_3;
  logic [DW-1:0] wb_ac_3, wb_data_3;
  logic [AW-1:0] branch_target_3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  mem_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_W(RW), .WAIT_CYCLES(1)) u1 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .wr(wr), .wm(wm), .rm(rm),
    .neq(neq), .j(j), .jc(jc), .zero(zero), .pc(pc), .reg_val(reg_val),
    .ac_value(ac_value), .rd_ex(rd_ex), .stall(stall_1), .wb_valid(wb_valid_1),
    .wb_wr(wb_wr_1), .wb_rm(wb_rm_1), .wb_rd(wb_rd_1), .wb_ac(wb_ac_1),
    .wb_data(wb_data_1), .branch_taken(branch_taken_1), .branch_target(branch_target_1)
  );

  mem_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .RD_W(RW), .WAIT_CYCLES(3)) u3 (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .wr(wr), .wm(wm), .rm(rm),
    .neq(neq), .j(j), .jc(jc), .zero(zero), .pc(pc), .reg_val(reg_val),
    .ac_value(ac_value), .rd_ex(rd_ex), .stall(stall_3), .wb_valid(wb_valid_3),
    .wb_wr(wb_wr_3), .wb_rm(wb_rm_3), .wb_rd(wb_rd_3), .wb_ac(wb_ac_3),
    .wb_data(wb_data_3), .branch_taken(branch_taken_3), .branch_target(branch_target_3)
  );

  task automatic clear_inputs();
    ex_valid = 1'b0; wr = 1'b0; wm = 1'b0; rm = 1'b0;
    neq = 1'b0; j = 1'b0; jc = 1'b0; zero = 1'b0;
    pc = '0; reg_val = '0; ac_value = '0; rd_ex = '0;
  endtask

  // Drop all requests and let the slower instance drain
  task automatic idle();
    clear_inputs();
    repeat (6) @(negedge clock);
  endtask

  // Wait for completion on instance 'which'; returns at the completion negedge with ex_valid low
  task automatic run_op(input int which, output int lat, output int stalls);
    lat = 0;
    stalls = 0;
    while (lat < 20) begin
      @(negedge clock);
      lat++;
      if ((which == 1) ? wb_valid_1 : wb_valid_3) break;
      if ((which == 1) ? stall_1 : stall_3) stalls++;
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    compared++;
    if ({stall_1, wb_valid_1, wb_wr_1, wb_rm_1, wb_rd_1, wb_ac_1, wb_data_1,
         branch_taken_1, branch_target_1} !== '0) begin
      mismatched++;
      $display("FAIL reset_u1: got valid=%b ac=%h data=%h stall=%b required all zero",
               wb_valid_1, wb_ac_1, wb_data_1, stall_1);
    end
    compared++;
    if ({stall_3, wb_valid_3, wb_wr_3, wb_rm_3, wb_rd_3, wb_ac_3, wb_data_3,
         branch_taken_3, branch_target_3} !== '0) begin
      mismatched++;
      $display("FAIL reset_u3: got valid=%b ac=%h data=%h stall=%b required all zero",
               wb_valid_3, wb_ac_3, wb_data_3, stall_3);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_nonmem();
    ex_valid = 1'b1; wr = 1'b1; rd_ex = 2'd2; ac_value = 8'h3C;
    #1;
    compared++;
    if (stall_1 !== 1'b0) begin
      mismatched++; $display("FAIL nonmem_stall: got %b required 0", stall_1);
    end
    @(negedge clock);
    compared++;
    if ({wb_valid_1, wb_wr_1, wb_rd_1, wb_ac_1, stall_1} !== {1'b1, 1'b1, 2'd2, 8'h3C, 1'b0}) begin
      mismatched++;
      $display("FAIL nonmem_wb: got valid=%b wr=%b rd=%0d ac=%h stall=%b required 1 1 2 3c 0",
               wb_valid_1, wb_wr_1, wb_rd_1, wb_ac_1, stall_1);
    end
    ex_valid = 1'b0; ac_value = 8'h00;
    @(negedge clock);
    compared++;
    if ({wb_valid_1, wb_ac_1, wb_rd_1} !== {1'b0, 8'h3C, 2'd2}) begin
      mismatched++;
      $display("FAIL nonmem_hold: got valid=%b ac=%h rd=%0d required 0 3c 2",
               wb_valid_1, wb_ac_1, wb_rd_1);
    end
  endtask

  task automatic test_store_load();
    int lat, stalls;
    ex_valid = 1'b1; wm = 1'b1; ac_value = 8'h10; reg_val = 8'hA5;
    #1;
    compared++;
    if (stall_1 !== 1'b1) begin
      mismatched++; $display("FAIL store_issue_stall: got %b required 1", stall_1);
    end
    run_op(1, lat, stalls);
    compared++;
    if (lat != 2 || stalls != 1) begin
      mismatched++;
      $display("FAIL store_timing: got latency=%0d stalls=%0d required 2 1", lat, stalls);
    end
    ex_valid = 1'b1; wm = 1'b0; rm = 1'b1; ac_value = 8'h10; reg_val = 8'h00;
    run_op(1, lat, stalls);
    compared++;
    if (lat != 2 || stalls != 1) begin
      mismatched++;
      $display("FAIL load_timing: got latency=%0d stalls=%0d required 2 1", lat, stalls);
    end
    compared++;
    if ({wb_data_1, wb_rm_1} !== {8'hA5, 1'b1}) begin
      mismatched++;
      $display("FAIL load_data: got data=%h rm=%b required a5 1", wb_data_1, wb_rm_1);
    end
    rm = 1'b0;
  endtask

  task automatic test_rmw();
    int lat, stalls;
    ex_valid = 1'b1; wm = 1'b1; ac_value = 8'h20; reg_val = 8'h11;
    run_op(3, lat, stalls);
    ex_valid = 1'b1; rm = 1'b1; wm = 1'b1; ac_value = 8'h20; reg_val = 8'h77;
    run_op(3, lat, stalls);
    compared++;
    if (lat != 4 || stalls != 3) begin
      mismatched++;
      $display("FAIL rmw_timing: got latency=%0d stalls=%0d required 4 3", lat, stalls);
    end
    compared++;
    if ({wb_data_3, wb_rm_3} !== {8'h11, 1'b1}) begin
      mismatched++;
      $display("FAIL rmw_old_data: got data=%h rm=%b required 11 1", wb_data_3, wb_rm_3);
    end
    ex_valid = 1'b1; rm = 1'b1; wm = 1'b0; ac_value = 8'h20; reg_val = 8'h00;
    run_op(3, lat, stalls);
    compared++;
    if (wb_data_3 !== 8'h77) begin
      mismatched++; $display("FAIL rmw_new_data: got %h required 77", wb_data_3);
    end
    rm = 1'b0;
  endtask

  task automatic test_jumps();
    logic [3:0] vec [4];
    logic       exp [4];
    // {j, jc, neq, zero}
    vec[0] = 4'b0101; exp[0] = 1'b1;
    vec[1] = 4'b0111; exp[1] = 1'b0;
    vec[2] = 4'b1000; exp[2] = 1'b1;
    vec[3] = 4'b0110; exp[3] = 1'b1;
    pc = 8'h40;
    for (int i = 0; i < 4; i++) begin
      ex_valid = 1'b1;
      {j, jc, neq, zero} = vec[i];
      @(negedge clock);
      compared++;
      if ({wb_valid_1, branch_taken_1, branch_target_1} !== {1'b1, exp[i], 8'h40}) begin
        mismatched++;
        $display("FAIL jump_%0d: got valid=%b taken=%b target=%h required 1 %b 40",
                 i, wb_valid_1, branch_taken_1, branch_target_1, exp[i]);
      end
    end
    ex_valid = 1'b0; j = 1'b1; jc = 1'b0; zero = 1'b0;
    @(negedge clock);
    compared++;
    if ({wb_valid_1, branch_taken_1} !== 2'b00) begin
      mismatched++;
      $display("FAIL jump_invalid: got valid=%b taken=%b required 0 0", wb_valid_1, branch_taken_1);
    end
    j = 1'b0;
  endtask

  task automatic test_reset_busy();
    int lat, stalls;
    ex_valid = 1'b1; wm = 1'b1; ac_value = 8'h30; reg_val = 8'h5A;
    run_op(3, lat, stalls);
    ex_valid = 1'b1; wm = 1'b1; ac_value = 8'h30; reg_val = 8'h99;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; ex_valid = 1'b0;
    #1;
    compared++;
    if ({stall_3, wb_valid_3, wb_wr_3, wb_rm_3, wb_rd_3, wb_ac_3, wb_data_3,
         branch_taken_3, branch_target_3} !== '0) begin
      mismatched++;
      $display("FAIL reset_busy: got stall=%b valid=%b ac=%h data=%h required all zero",
               stall_3, wb_valid_3, wb_ac_3, wb_data_3);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    ex_valid = 1'b1; rm = 1'b1; ac_value = 8'h30;
    run_op(3, lat, stalls);
    compared++;
    if (wb_data_3 !== 8'h5A) begin
      mismatched++; $display("FAIL reset_no_write: got %h required 5a", wb_data_3);
    end
    rm = 1'b0;
  endtask

  task automatic test_wrap();
    int lat, stalls;
    ex_valid = 1'b1; wm = 1'b1; ac_value = 8'hFF; reg_val = 8'hC3;
    run_op(1, lat, stalls);
    ex_valid = 1'b1; wm = 1'b0; rm = 1'b1; ac_value = 8'hFF; reg_val = 8'h00;
    run_op(1, lat, stalls);
    compared++;
    if (wb_data_1 !== 8'hC3) begin
      mismatched++; $display("FAIL wrap_read: got %h required c3", wb_data_1);
    end
    rm = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] acs [4];
    acs[0] = 8'h01; acs[1] = 8'h82; acs[2] = 8'h43; acs[3] = 8'hE4;
    wr = 1'b1;
    ex_valid = 1'b1; ac_value = acs[0]; rd_ex = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      compared++;
      if ({wb_valid_1, wb_ac_1, wb_rd_1, stall_1} !== {1'b1, acs[i], 2'(i), 1'b0}) begin
        mismatched++;
        $display("FAIL b2b_%0d: got valid=%b ac=%h rd=%0d stall=%b required 1 %h %0d 0",
                 i, wb_valid_1, wb_ac_1, wb_rd_1, stall_1, acs[i], i);
      end
      if (i < 3) begin
        ac_value = acs[i+1];
        rd_ex    = 2'(i + 1);
      end else begin
        ex_valid = 1'b0;
      end
    end
    @(negedge clock);
    compared++;
    if (wb_valid_1 !== 1'b0) begin
      mismatched++; $display("FAIL b2b_end: got valid=%b required 0", wb_valid_1);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    test_reset();
    test_nonmem();
    idle();
    test_store_load();
    idle();
    test_rmw();
    idle();
    test_jumps();
    idle();
    test_reset_busy();
    idle();
    test_wrap();
    idle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
Parametrised memory-access pipeline stage for the processor core, placed between EX and WB. It registers the EX results into a MEM/WB pipeline register and resolves jump/conditional-jump decisions. It performs data-memory reads and writes against an internal RAM with a configurable number of wait states, stalling upstream with a stall/valid handshake while an access is in flight.

Parameters:
DATA_W, 8, data and accumulator width
ADDR_W, 8, data-memory address width and PC width; RAM depth is 2**ADDR_W
RD_W, 2, destination-register index width
WAIT_CYCLES, 1, extra cycles per memory access (0 = single-cycle access)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  EX presents a valid instruction
wr  in  1  register write-back enable
wm  in  1  memory write
rm  in  1  memory read
neq  in  1  conditional jump on not-equal (else jump on equal)
j  in  1  unconditional jump
jc  in  1  conditional jump
zero  in  1  ALU zero flag
pc  in  ADDR_W  jump target
reg_val  in  DATA_W  store data
ac_value  in  DATA_W  ALU result; low ADDR_W bits are the memory address
rd_ex  in  RD_W  destination register
stall  out  1  EX must hold its inputs stable
wb_valid  out  1  one-cycle pulse: MEM/WB register holds a completed instruction
wb_wr  out  1  registered wr
wb_rm  out  1  registered rm (WB selects wb_data over wb_ac)
wb_rd  out  RD_W  registered rd_ex
wb_ac  out  DATA_W  registered ac_value
wb_data  out  DATA_W  read data
branch_taken  out  1  registered jump decision, qualified by wb_valid
branch_target  out  ADDR_W  registered pc

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, FSM to IDLE, wait counter 0. RAM contents are not cleared. Reset while BUSY aborts the access; no RAM write occurs.
- FSM states: IDLE, BUSY.
- IDLE, ex_valid=0: wb_valid=0 next cycle; all other wb_* outputs hold their values.
- IDLE, ex_valid=1, rm=wm=0: MEM/WB register loads next edge; wb_valid=1 for 1 cycle; latency 1.
- IDLE, ex_valid=1, (rm|wm), WAIT_CYCLES=0: access completes at the next edge; latency 1; stall stays 0.
- IDLE, ex_valid=1, (rm|wm), WAIT_CYCLES>0: enter BUSY and load counter=WAIT_CYCLES. stall is combinationally 1 in this cycle and throughout BUSY.
- BUSY: counter decrements each edge. At the edge where counter==1:
  - perform the access;
  - load the MEM/WB register from the held inputs;
  - pulse wb_valid;
  - return to IDLE; stall deasserts.
  - Total latency is WAIT_CYCLES+1 cycles. Inputs are sampled only at the completion edge; they must be stable under stall.
- Memory: address = ac_value[ADDR_W-1:0]. A write stores reg_val. A read returns RAM[address] into wb_data. With rm=wm=1, the read returns the old contents (read-before-write) and the write still occurs. When rm=0, wb_data holds its previous value.
- Jump: taken = j | (jc & (neq ? ~zero : zero)). branch_taken and branch_target are registered with the MEM/WB load. branch_taken is forced to 0 on cycles where wb_valid=0. j takes priority; j=jc=1 is taken.
- Address wraps naturally at 2**ADDR_W; no bounds error. Widths are fixed per parameter; no extension or truncation beyond taking the ADDR_W LSBs of ac_value.
- Back-to-back: a new instruction is accepted in the same cycle the FSM returns to IDLE (the cycle after completion). There are no bubbles for non-memory streams.

Test Plan:
- Reset, then ex_valid=1, wr=1, rd_ex=2, ac_value=0x3C, no mem op -> next cycle wb_valid=1, wb_rd=2, wb_ac=0x3C, wb_wr=1, stall never 1.
- WAIT_CYCLES=1: store wm=1, ac_value=0x10, reg_val=0xA5, then load rm=1 at 0x10 -> each op has stall=1 for 1 cycle; load completes 2 cycles after issue with wb_data=0xA5, wb_rm=1.
- WAIT_CYCLES=3, rm=wm=1 at 0x20 (old 0x11, reg_val 0x77) -> stall 3 cycles, wb_data=0x11; a subsequent read of 0x20 gives 0x77.
- Jumps with pc=0x40: jc=1, neq=0, zero=1 -> branch_taken=1, branch_target=0x40; jc=1, neq=1, zero=1 -> 0; j=1, zero=0 -> 1; ex_valid=0 with j=1 -> 0.
- Assert reset in the 2nd BUSY cycle of a store to 0x30 (WAIT_CYCLES=3) -> outputs immediately 0, FSM IDLE; a later read of 0x30 returns the pre-store value.
- Address wrap, ADDR_W=8: store at ac_value=0xFF, then read 0xFF -> value returned; stream of 4 non-mem ops -> 4 consecutive wb_valid pulses.
